lpf_channel_scheduler: RTL and testbench
========================================

# lpf_channel_scheduler

Time-multiplexed first-order IIR low/high-pass engine shared by NCH sample streams. A round-robin arbiter grants one requesting channel per cycle into a single two-stage update pipeline. Each channel keeps its own filter state and configuration (shift, on, highpass). The block sits between the ADC/demodulator outputs and the PID/IQ consumers, replacing NCH separate filter blocks.

## Interface
- NCH, 4, number of channels (2..16)
- CHBITS, 2, channel index width, equal to ceil(log2(NCH))
- SIGNALBITS, 14, signed sample width
- SHIFTBITS, 4, shift field is SHIFTBITS+1 bits wide
- MAXSHIFT, 24, fractional state bits; effective shift = min(shift, MAXSHIFT)

Ports:
- clk_i  in  1  sole clock
- rst_i  in  1  asynchronous, active-high reset
- req_i  in  NCH  per-channel request; level, held until acked
- data_i  in  NCH*SIGNALBITS  signed samples; channel k at [k*SIGNALBITS +: SIGNALBITS]; stable while req high
- ack_o  out  NCH  one-hot, combinational grant; sample is taken at the clock edge where ack is high
- cfg_we_i  in  1  write cfg_shift_i/cfg_on_i/cfg_hp_i to channel cfg_ch_i
- cfg_clr_i  in  1  zero the state of channel cfg_ch_i
- cfg_ch_i  in  CHBITS  config target channel
- cfg_shift_i  in  SHIFTBITS+1  shift value
- cfg_on_i  in  1  filter enable
- cfg_hp_i  in  1  1 = highpass output
- out_valid_o  out  1  result strobe, one cycle
- out_ch_o  out  CHBITS  channel of the result
- out_data_o  out  SIGNALBITS  signed result

## Operation
- **State.** Per channel, y[k] is signed, SIGNALBITS+MAXSHIFT bits. y_out[k] = y[k][top SIGNALBITS bits].
- **Arbitration.**
  - Eligible = req_i AND NOT lockout. The lockout mask is the channel granted in the previous cycle.
  - Grant the first eligible channel, searching upward from ptr with wrap.
  - On a grant, ptr <= granted+1 (mod NCH). With no grant, ptr holds.
  - At most one ack bit is high per cycle.
- **Lockout.** It removes the read-after-write hazard: a lone requester is granted every other cycle.
- **Stage 1 (edge after grant).** Register the following:
  - ch
  - x
  - cfg snapshot (eff_shift, on, hp)
  - delta = x − y_out[ch], computed at SIGNALBITS+1 bits
- **Stage 2 (next edge).**
  - If on=1: y[ch] <= y[ch] + (delta << eff_shift). Add at SIGNALBITS+MAXSHIFT+1 bits, then truncate; the result is bounded by x, so no overflow.
  - If on=0: y is unchanged.
- **Output (same edge as stage 2).**
  - out_valid=1 and out_ch=ch.
  - out_data is:
    - on=0: x (passthrough)
    - hp=0: the new y_out
    - hp=1: delta saturated to [−2^(SIGNALBITS−1), 2^(SIGNALBITS−1)−1]
- **Config write.** Applies to grants in the following cycles. In-flight samples use their stage-1 snapshot.
- **Clear.**
  - Zeroes y[cfg_ch_i] at the edge, and wins over a same-edge stage-2 write to that channel.
  - A stage-1 entry for the cleared channel is invalidated: no state write, no output.
  - cfg_clr_i and cfg_we_i may be asserted together; both take effect.
- **Reset.** Drives all y, cfg (shift=0, on=0, hp=0), ptr, lockout and pipeline valids to 0. Outputs are 0 during and after reset until the first result.

## Timing
- Grant in cycle N (ack_o high in N). out_valid_o is high in cycle N+2, registered. Latency is 2.
- Throughput: 1 sample/cycle aggregate. A single channel is limited to 1 per 2 cycles.
- No backpressure on the output: consumers must accept every valid cycle.
- Asynchronous reset mid-stream drops all in-flight samples. No output appears for them.
- All outputs are driven from registers except ack_o.

## Test plan
1. **Reset.** Assert rst_i mid-stream with 2 samples in flight → ack_o=0, out_valid_o=0, out_data_o=0 immediately; no stale outputs after release.
2. **Step, ch0.** on=1, hp=0.
   - shift=24, x=1000 → out 1000 at N+2.
   - Clear, set shift=23, hold x=1000 → successive outputs 500, 750, 875, 937.
3. **Fairness.** All 4 req held; each channel's grant stays in the lockout mask for the cycle after its grant.
   - After the first cycle, grants run in a strict 0,1,2,3,0,… rotation.
   - Each channel gets one sample every 4 cycles, with no gaps.
4. **Lockout.** Only ch2 requests continuously → acks in alternating cycles. Outputs match the software recursion exactly, including over 100 random samples.
5. **Highpass saturation.** ch1 shift=24.
   - Feed x=−8192 with hp=0 → y_out=−8192.
   - Set hp=1 and feed x=8191 → out 8191 (raw delta 16383).
   - Set on=0 and feed x=−5 → out −5, y unchanged.
6. **Collision.** Assert cfg_clr_i for ch3 on the edge its sample enters stage 1 → no output for that sample, y[3]=0. Assert cfg_we_i in the same cycle as a grant → the in-flight result uses the old shift.

Source files
------------

// File: rtl/lpf_channel_scheduler.sv
// Shared first-order IIR low/high-pass engine for NCH channels: a round-robin
// arbiter with one-cycle lockout feeds a two-stage per-channel state update.
module lpf_channel_scheduler #(
  parameter int NCH        = 4,
  parameter int CHBITS     = 2,
  parameter int SIGNALBITS = 14,
  parameter int SHIFTBITS  = 4,
  parameter int MAXSHIFT   = 24
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NCH-1:0]             req_i,
  input  logic [NCH*SIGNALBITS-1:0]  data_i,
  output logic [NCH-1:0]             ack_o,
  input  logic                       cfg_we_i,
  input  logic                       cfg_clr_i,
  input  logic [CHBITS-1:0]          cfg_ch_i,
  input  logic [SHIFTBITS:0]         cfg_shift_i,
  input  logic                       cfg_on_i,
  input  logic                       cfg_hp_i,
  output logic                       out_valid_o,
  output logic [CHBITS-1:0]          out_ch_o,
  output logic [SIGNALBITS-1:0]      out_data_o
);
  localparam int YW = SIGNALBITS + MAXSHIFT;
  localparam int unsigned NCHU = NCH;
  localparam logic [SHIFTBITS:0] SHMAX = (SHIFTBITS+1)'(MAXSHIFT);

  typedef logic signed [YW-1:0] y_t;

  y_t                    y_q [NCH];
  y_t                    y_d [NCH];
  logic [SHIFTBITS:0]    shift_q [NCH];
  logic [SHIFTBITS:0]    shift_d [NCH];
  logic [NCH-1:0]        on_q, on_d, hp_q, hp_d;
  logic [CHBITS-1:0]     ptr_q, ptr_d;
  logic [NCH-1:0]        lock_q, lock_d;

  logic                  s1_valid_q, s1_valid_d;
  logic [CHBITS-1:0]     s1_ch_q, s1_ch_d;
  logic [SIGNALBITS-1:0] s1_x_q, s1_x_d;
  logic [SHIFTBITS:0]    s1_shift_q, s1_shift_d;
  logic                  s1_on_q, s1_on_d, s1_hp_q, s1_hp_d;
  logic [SIGNALBITS:0]   s1_delta_q, s1_delta_d;

  logic                  out_valid_q, out_valid_d;
  logic [CHBITS-1:0]     out_ch_q, out_ch_d;
  logic [SIGNALBITS-1:0] out_data_q, out_data_d;

  logic                  gnt_v;
  logic [CHBITS-1:0]     gnt_ch, arb_idx;
  logic [NCH-1:0]        elig;
  logic [SIGNALBITS-1:0] gnt_x, gnt_yout;

  logic                  s2_fire;
  y_t                    s2_y;
  logic [SIGNALBITS-1:0] s2_yout, s2_sat;

  // Excluding last cycle's grant keeps a channel from reading y before its
  // previous update has been written back.
  always_comb begin
    elig    = req_i & ~lock_q;
    gnt_v   = 1'b0;
    gnt_ch  = '0;
    arb_idx = '0;
    for (int unsigned i = 0; i < NCHU; i++) begin
      arb_idx = CHBITS'((32'(ptr_q) + i) % NCHU);
      if (!gnt_v && elig[arb_idx]) begin
        gnt_v  = 1'b1;
        gnt_ch = arb_idx;
      end
    end
    if (rst_i) gnt_v = 1'b0;
    ack_o = '0;
    if (gnt_v) ack_o[gnt_ch] = 1'b1;
    lock_d = ack_o;
    ptr_d  = ptr_q;
    if (gnt_v) ptr_d = (32'(gnt_ch) == NCHU - 1) ? '0 : gnt_ch + 1'b1;
  end

  always_comb begin
    gnt_x      = data_i[gnt_ch*SIGNALBITS +: SIGNALBITS];
    gnt_yout   = y_q[gnt_ch][YW-1 -: SIGNALBITS];
    s1_valid_d = gnt_v && !(cfg_clr_i && cfg_ch_i == gnt_ch);
    s1_ch_d    = gnt_ch;
    s1_x_d     = gnt_x;
    s1_shift_d = (shift_q[gnt_ch] > SHMAX) ? SHMAX : shift_q[gnt_ch];
    s1_on_d    = on_q[gnt_ch];
    s1_hp_d    = hp_q[gnt_ch];
    s1_delta_d = {gnt_x[SIGNALBITS-1], gnt_x} - {gnt_yout[SIGNALBITS-1], gnt_yout};
  end

  // The sum is bounded by x, so adding at YW bits equals add-then-truncate.
  always_comb begin
    s2_fire = s1_valid_q && !(cfg_clr_i && cfg_ch_i == s1_ch_q);
    s2_y    = y_q[s1_ch_q]
            + ({{(YW-SIGNALBITS-1){s1_delta_q[SIGNALBITS]}}, s1_delta_q} << s1_shift_q);
    s2_yout = s2_y[YW-1 -: SIGNALBITS];
    if (s1_delta_q[SIGNALBITS] != s1_delta_q[SIGNALBITS-1])
      s2_sat = s1_delta_q[SIGNALBITS] ? {1'b1, {(SIGNALBITS-1){1'b0}}}
                                      : {1'b0, {(SIGNALBITS-1){1'b1}}};
    else
      s2_sat = s1_delta_q[SIGNALBITS-1:0];

    y_d     = y_q;
    shift_d = shift_q;
    on_d    = on_q;
    hp_d    = hp_q;
    if (s2_fire && s1_on_q) y_d[s1_ch_q] = s2_y;
    if (cfg_clr_i) y_d[cfg_ch_i] = '0;
    if (cfg_we_i) begin
      shift_d[cfg_ch_i] = cfg_shift_i;
      on_d[cfg_ch_i]    = cfg_on_i;
      hp_d[cfg_ch_i]    = cfg_hp_i;
    end

    out_valid_d = s2_fire;
    out_ch_d    = out_ch_q;
    out_data_d  = out_data_q;
    if (s2_fire) begin
      out_ch_d = s1_ch_q;
      if (!s1_on_q)      out_data_d = s1_x_q;
      else if (!s1_hp_q) out_data_d = s2_yout;
      else               out_data_d = s2_sat;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned k = 0; k < NCHU; k++) begin
        y_q[k]     <= '0;
        shift_q[k] <= '0;
      end
      on_q        <= '0;
      hp_q        <= '0;
      ptr_q       <= '0;
      lock_q      <= '0;
      s1_valid_q  <= 1'b0;
      s1_ch_q     <= '0;
      s1_x_q      <= '0;
      s1_shift_q  <= '0;
      s1_on_q     <= 1'b0;
      s1_hp_q     <= 1'b0;
      s1_delta_q  <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_data_q  <= '0;
    end else begin
      y_q         <= y_d;
      shift_q     <= shift_d;
      on_q        <= on_d;
      hp_q        <= hp_d;
      ptr_q       <= ptr_d;
      lock_q      <= lock_d;
      s1_valid_q  <= s1_valid_d;
      s1_ch_q     <= s1_ch_d;
      s1_x_q      <= s1_x_d;
      s1_shift_q  <= s1_shift_d;
      s1_on_q     <= s1_on_d;
      s1_hp_q     <= s1_hp_d;
      s1_delta_q  <= s1_delta_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_ch_o    = out_ch_q;
  assign out_data_o  = out_data_q;

endmodule

// File: tb/tb_lpf_channel_scheduler.sv
// Scoreboard bench for lpf_channel_scheduler: an arithmetic reference model
// predicts each result at grant time; a monitor checks every output strobe.
module tb_lpf_channel_scheduler;
  localparam int NCH = 4, CHBITS = 2, SB = 14, SHB = 4, MS = 24;

  logic clk = 1'b0;
  logic rst_i;
  logic [NCH-1:0] req_i, ack_o;
  logic [NCH*SB-1:0] data_i;
  logic cfg_we_i, cfg_clr_i, cfg_on_i, cfg_hp_i;
  logic [CHBITS-1:0] cfg_ch_i;
  logic [SHB:0] cfg_shift_i;
  logic out_valid_o;
  logic [CHBITS-1:0] out_ch_o;
  logic [SB-1:0] out_data_o;

  always #5 clk = ~clk;

  lpf_channel_scheduler #(.NCH(NCH), .CHBITS(CHBITS), .SIGNALBITS(SB),
                          .SHIFTBITS(SHB), .MAXSHIFT(MS)) dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .data_i(data_i), .ack_o(ack_o),
    .cfg_we_i(cfg_we_i), .cfg_clr_i(cfg_clr_i), .cfg_ch_i(cfg_ch_i),
    .cfg_shift_i(cfg_shift_i), .cfg_on_i(cfg_on_i), .cfg_hp_i(cfg_hp_i),
    .out_valid_o(out_valid_o), .out_ch_o(out_ch_o), .out_data_o(out_data_o));

  typedef struct { int ch; int data; int edge_n; } exp_t;

  int errors = 0, checks = 0, edge_cnt = 0;
  exp_t sb_q[$];
  int got_data_q[$];
  int got_ch_q[$];
  int grant_log[$];

  longint y_m[NCH];
  int sh_m[NCH];
  bit on_m[NCH], hp_m[NCH];
  bit pend_v = 0;
  exp_t pend;
  logic [NCH-1:0] last_ack = '0, prev_ack = '0;

  int cnt[NCH], fix_x[NCH];
  bit rnd_x[NCH];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint wrap_y(input longint v);
    return (v <<< (64 - SB - MS)) >>> (64 - SB - MS);
  endfunction

  function automatic int yout(input longint y);
    return int'(y >>> MS);
  endfunction

  function automatic int clamp(input int v);
    if (v > 8191) return 8191;
    if (v < -8192) return -8192;
    return v;
  endfunction

  function automatic int oh_idx(input logic [NCH-1:0] v);
    for (int i = 0; i < NCH; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Reference model: a sample is updated atomically at its grant edge.
  initial begin
    logic [NCH-1:0] elig;
    int g, x, s, d;
    forever begin
      @(posedge clk);
      edge_cnt++;
      if (rst_i) begin
        sb_q.delete();
        pend_v = 0;
        for (int k = 0; k < NCH; k++) begin
          y_m[k] = 0; sh_m[k] = 0; on_m[k] = 0; hp_m[k] = 0;
        end
        prev_ack = '0;
        last_ack = '0;
      end else begin
        elig = req_i & ~prev_ack;
        if (req_i != '0) begin
          checks++;
          if (!($onehot0(ack_o) && ((ack_o & ~elig) == '0) && ((elig != '0) == (ack_o != '0)))) begin
            errors++;
            $display("FAIL arbiter: got ack=%b expected one grant among eligible=%b", ack_o, elig);
          end
        end
        if (req_i == '1) grant_log.push_back(oh_idx(ack_o));
        if (pend_v) begin
          if (!(cfg_clr_i && int'(cfg_ch_i) == pend.ch)) begin
            pend.edge_n = edge_cnt;
            sb_q.push_back(pend);
          end
          pend_v = 0;
        end
        g = oh_idx(ack_o);
        if (g >= 0 && !(cfg_clr_i && int'(cfg_ch_i) == g)) begin
          x = $signed(data_i[g*SB +: SB]);
          s = (sh_m[g] > MS) ? MS : sh_m[g];
          d = x - yout(y_m[g]);
          if (on_m[g]) y_m[g] = wrap_y(y_m[g] + (longint'(d) <<< s));
          pend.ch   = g;
          pend.data = !on_m[g] ? x : (!hp_m[g] ? yout(y_m[g]) : clamp(d));
          pend_v    = 1;
        end
        if (cfg_clr_i) y_m[cfg_ch_i] = 0;
        if (cfg_we_i) begin
          sh_m[cfg_ch_i] = int'(cfg_shift_i);
          on_m[cfg_ch_i] = cfg_on_i;
          hp_m[cfg_ch_i] = cfg_hp_i;
        end
        prev_ack = ack_o;
        last_ack = ack_o;
      end
    end
  end

  // Monitor: each strobe must match the entry predicted for exactly this edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb_q.size() > 0 && sb_q[0].edge_n < edge_cnt) begin
        checks++; errors++;
        $display("FAIL missing_out: got no strobe expected ch=%0d data=%0d", sb_q[0].ch, sb_q[0].data);
        void'(sb_q.pop_front());
      end
      if (!rst_i && out_valid_o) begin
        if (sb_q.size() > 0 && sb_q[0].edge_n == edge_cnt) begin
          e = sb_q.pop_front();
          chk("out_ch", out_ch_o, e.ch);
          chk("out_data", $signed(out_data_o), e.data);
        end else begin
          checks++; errors++;
          $display("FAIL unexpected_out: got ch=%0d data=%0d expected no strobe",
                   out_ch_o, $signed(out_data_o));
        end
        got_ch_q.push_back(int'(out_ch_o));
        got_data_q.push_back($signed(out_data_o));
      end
    end
  end

  task automatic step();
    @(negedge clk);
    cfg_we_i  = 1'b0;
    cfg_clr_i = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      if (last_ack[k]) cnt[k]--;
      if (last_ack[k] || !req_i[k]) begin
        req_i[k] = cnt[k] > 0;
        data_i[k*SB +: SB] = rnd_x[k] ? SB'($urandom) : SB'(fix_x[k]);
      end
    end
  endtask

  task automatic drain();
    int guard = 0;
    bit busy = 1;
    while (busy && guard < 2000) begin
      step();
      guard++;
      busy = (req_i != '0) || (sb_q.size() > 0) || pend_v;
    end
    if (busy) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got busy after %0d cycles expected idle", guard);
    end
    step();
  endtask

  task automatic cfg_write(input int ch, input int sh, input bit on, input bit hp);
    cfg_we_i    = 1'b1;
    cfg_ch_i    = CHBITS'(ch);
    cfg_shift_i = (SHB+1)'(sh);
    cfg_on_i    = on;
    cfg_hp_i    = hp;
  endtask

  task automatic send1(input int ch, input int x, output int res);
    fix_x[ch] = x; rnd_x[ch] = 0; cnt[ch] = 1;
    drain();
    res = (got_data_q.size() > 0) ? got_data_q[$] : 99999;
  endtask

  initial begin
    int r, n0;
    int step23[4] = '{500, 750, 875, 937};
    rst_i = 1'b1; req_i = '1; data_i = '0;
    cfg_we_i = 0; cfg_clr_i = 0; cfg_ch_i = '0; cfg_shift_i = '0; cfg_on_i = 0; cfg_hp_i = 0;
    for (int k = 0; k < NCH; k++) begin cnt[k] = 0; fix_x[k] = 0; rnd_x[k] = 0; end
    repeat (3) @(negedge clk);
    chk("rst_ack", ack_o, 0);
    chk("rst_valid", out_valid_o, 0);
    chk("rst_data", out_data_o, 0);
    req_i = '0;
    rst_i = 1'b0;
    step();
    chk("post_rst_valid", out_valid_o, 0);

    // Step response on ch0
    step(); cfg_write(0, 24, 1, 0);
    send1(0, 1000, r); chk("step_s24", r, 1000);
    step(); cfg_write(0, 23, 1, 0); cfg_clr_i = 1'b1;
    n0 = got_data_q.size();
    fix_x[0] = 1000; cnt[0] = 4; drain();
    chk("step_s23_count", got_data_q.size() - n0, 4);
    if (got_data_q.size() - n0 == 4)
      for (int i = 0; i < 4; i++) chk("step_s23", got_data_q[n0+i], step23[i]);

    // Fairness: all channels requesting continuously
    for (int k = 0; k < NCH; k++) begin
      step(); cfg_write(k, $urandom_range(0, 31), 1, 1'($urandom));
    end
    grant_log.delete();
    for (int k = 0; k < NCH; k++) begin rnd_x[k] = 1; cnt[k] = 40; end
    drain();
    chk("fair_first_grant_valid", grant_log.size() > 0 && grant_log[0] >= 0, 1);
    for (int i = 1; i < grant_log.size(); i++)
      chk("fair_rotation", grant_log[i], (grant_log[i-1] + 1) % NCH);

    // Lone requester with random samples and two configurations
    step(); cfg_write(2, $urandom_range(0, 31), 1, 0);
    rnd_x[2] = 1; cnt[2] = 100; drain();
    step(); cfg_write(2, $urandom_range(10, 24), 1, 1);
    rnd_x[2] = 1; cnt[2] = 100; drain();

    // Highpass saturation and passthrough on ch1
    step(); cfg_write(1, 24, 1, 0); send1(1, -8192, r); chk("hp_load", r, -8192);
    step(); cfg_write(1, 24, 1, 1); send1(1, 8191, r); chk("hp_sat_pos", r, 8191);
    step(); cfg_write(1, 24, 0, 1); send1(1, -5, r); chk("off_pass", r, -5);
    step(); cfg_write(1, 0, 1, 0); send1(1, 8191, r); chk("off_keeps_y", r, 8191);
    step(); cfg_write(1, 24, 1, 1); send1(1, -8192, r); chk("hp_sat_neg", r, -8192);

    // Clear colliding with stage-1 entry, then config write during a grant
    step(); cfg_write(3, 24, 1, 0); send1(3, 100, r); chk("col_load", r, 100);
    n0 = got_data_q.size();
    fix_x[3] = 300; cnt[3] = 1;
    step(); #1;
    chk("col_ack", ack_o[3], 1);
    cfg_clr_i = 1'b1; cfg_ch_i = 2'd3;
    drain();
    chk("col_no_out", got_data_q.size() - n0, 0);
    step(); cfg_write(3, 23, 1, 0); send1(3, 200, r); chk("col_y_zero", r, 100);
    step(); cfg_write(3, 24, 1, 0);
    fix_x[3] = 400; cnt[3] = 1;
    step(); #1;
    cfg_write(3, 23, 1, 0);
    drain();
    chk("inflight_old_shift", got_data_q.size() > 0 ? got_data_q[$] : 99999, 400);
    send1(3, 0, r); chk("new_shift_applies", r, 200);

    // Random traffic with interleaved config writes and clears
    for (int k = 0; k < NCH; k++) rnd_x[k] = 1;
    for (int c = 0; c < 500; c++) begin
      step();
      for (int k = 0; k < NCH; k++)
        if (cnt[k] == 0 && $urandom_range(0, 3) == 0) cnt[k] = $urandom_range(1, 5);
      if ($urandom_range(0, 7) == 0)
        cfg_write($urandom_range(0, NCH-1), $urandom_range(0, 31), 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 9) == 0) begin
        cfg_clr_i = 1'b1;
        if (!cfg_we_i) cfg_ch_i = CHBITS'($urandom_range(0, NCH-1));
      end
    end
    drain();

    // Reset mid-stream with samples in flight
    for (int k = 0; k < NCH; k++) cnt[k] = 20;
    repeat (5) step();
    #2 rst_i = 1'b1;
    #1;
    chk("midrst_ack", ack_o, 0);
    chk("midrst_valid", out_valid_o, 0);
    chk("midrst_data", out_data_o, 0);
    repeat (2) @(negedge clk);
    for (int k = 0; k < NCH; k++) cnt[k] = 0;
    req_i = '0;
    rst_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("after_rst_quiet", out_valid_o, 0);
    end
    send1(0, 1234, r); chk("rst_cfg_passthrough", r, 1234);

    chk("scoreboard_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
